// File: rtl/decade_timer_ctrl.sv
// Two-digit BCD timer with prescaler, one-shot/periodic modes and
// run/pause/done control. The counter compares against a latched BCD target
// and emits a one-cycle done pulse on every terminal event.
module decade_timer_ctrl #(
    parameter int unsigned PRESCALE = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [7:0] target,
    input  logic       auto_reload,
    output logic [3:0] cnt_lo,
    output logic [3:0] cnt_hi,
    output logic       cout_lo,
    output logic [1:0] state,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Last prescaler value before it wraps; the tick fires on this value.
    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    state_e     state_q, state_d;
    logic [3:0] lo_q, lo_d;
    logic [3:0] hi_q, hi_d;
    logic [7:0] presc_q, presc_d;
    logic [7:0] tgt_q, tgt_d;
    logic       auto_q, auto_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic [7:0] count_s;
    logic       tick_s;

    // Both target digits must be valid decimal digits.
    function automatic logic bcd_legal(input logic [7:0] value);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
    endfunction

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        logic [3:0] lo_v;
        logic [3:0] hi_v;
        lo_v = value[3:0];
        hi_v = value[7:4];
        if (lo_v == 4'd9) begin
            lo_v = 4'd0;
            if (hi_v == 4'd9) begin
                hi_v = 4'd0;
            end else begin
                hi_v = hi_v + 4'd1;
            end
        end else begin
            lo_v = lo_v + 4'd1;
        end
        return {hi_v, lo_v};
    endfunction

    assign count_s = {hi_q, lo_q};
    assign tick_s  = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    // Next-state, counter, prescaler and pulse logic; clear overrides everything.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        presc_d = presc_q;
        tgt_d   = tgt_q;
        auto_d  = auto_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            lo_d    = 4'd0;
            hi_d    = 4'd0;
            presc_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // stop outranks start, so a simultaneous stop blocks the start
                    if (start && !stop) begin
                        if (bcd_legal(target)) begin
                            tgt_d   = target;
                            auto_d  = auto_reload;
                            lo_d    = 4'd0;
                            hi_d    = 4'd0;
                            presc_d = 8'd0;
                            state_d = ST_RUN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        presc_d = 8'd0;
                        if (count_s == tgt_q) begin
                            done_d = 1'b1;
                            if (auto_q) begin
                                lo_d = 4'd0;
                                hi_d = 4'd0;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            {hi_d, lo_d} = bcd_inc(count_s);
                        end
                    end else begin
                        presc_d = presc_q + 8'd1;
                    end
                    // A one-shot terminal on the stop edge still finishes in DONE
                    if (stop && (state_d == ST_RUN)) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = state_d;
                    end
                end
                ST_PAUSE: begin
                    if (start && !stop) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters, latches and output pulses; async reset discards all progress.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            lo_q    <= 4'd0;
            hi_q    <= 4'd0;
            presc_q <= 8'd0;
            tgt_q   <= 8'd0;
            auto_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            presc_q <= presc_d;
            tgt_q   <= tgt_d;
            auto_q  <= auto_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cnt_lo  = lo_q;
    assign cnt_hi  = hi_q;
    assign cout_lo = (lo_q == 4'd9);
    assign state   = state_q;
    assign busy    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_decade_timer_ctrl.sv
// Directed bench for decade_timer_ctrl: one instance with PRESCALE=1 (a_*)
// and one with PRESCALE=2 (b_*), sharing the same command inputs.
module tb_decade_timer_ctrl;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       stop;
    logic       clear;
    logic [7:0] target;
    logic       auto_reload;

    logic [3:0] a_lo, a_hi, b_lo, b_hi;
    logic       a_cout, b_cout;
    logic [1:0] a_state, b_state;
    logic       a_busy, b_busy, a_done, b_done, a_err, b_err;

    int n_checks;
    int n_fail;

    decade_timer_ctrl #(.PRESCALE(1)) u_dut_a (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .clear(clear),
        .target(target), .auto_reload(auto_reload),
        .cnt_lo(a_lo), .cnt_hi(a_hi), .cout_lo(a_cout), .state(a_state),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    decade_timer_ctrl #(.PRESCALE(2)) u_dut_b (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .clear(clear),
        .target(target), .auto_reload(auto_reload),
        .cnt_lo(b_lo), .cnt_hi(b_hi), .cout_lo(b_cout), .state(b_state),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    // 10-unit clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance n clock edges and land 1 unit after the last one
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] bcd8(input int k);
        logic [3:0] hi_v;
        logic [3:0] lo_v;
        hi_v = 4'(k / 10);
        lo_v = 4'(k % 10);
        return {hi_v, lo_v};
    endfunction

    // Load a target and issue a single-edge start
    task automatic do_start(input logic [7:0] tgt, input logic rel);
        target      = tgt;
        auto_reload = rel;
        start       = 1'b1;
        step(1);
        start       = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rstn        = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        clear       = 1'b0;
        target      = 8'h00;
        auto_reload = 1'b0;

        // Reset state
        #1;
        check_eq("rst_state", 32'(a_state), 32'd0);
        check_eq("rst_cnt", 32'({a_hi, a_lo}), 32'h00);
        check_eq("rst_flags", 32'({a_busy, a_done, a_err, a_cout}), 32'd0);
        #11;
        rstn = 1'b1;
        step(2);
        check_eq("idle_after_rst", 32'(a_state), 32'd0);

        // One-shot count 00..12 with PRESCALE=1
        do_start(8'h12, 1'b0);
        check_eq("os_start_state", 32'(a_state), 32'd1);
        check_eq("os_start_cnt", 32'({a_hi, a_lo}), 32'h00);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check_eq("os_cnt", 32'({a_hi, a_lo}), 32'(bcd8(k)));
            check_eq("os_cout", 32'(a_cout), 32'((k % 10) == 9));
            check_eq("os_nodone", 32'(a_done), 32'd0);
        end
        step(1);
        check_eq("os_done", 32'(a_done), 32'd1);
        check_eq("os_state_done", 32'(a_state), 32'd3);
        check_eq("os_hold", 32'({a_hi, a_lo}), 32'h12);
        check_eq("os_busy", 32'(a_busy), 32'd0);
        step(2);
        check_eq("os_done_pulse", 32'(a_done), 32'd0);
        check_eq("os_hold2", 32'({a_hi, a_lo}), 32'h12);
        do_clear();
        check_eq("clr_state", 32'(a_state), 32'd0);
        check_eq("clr_cnt", 32'({b_hi, b_lo}), 32'h00);

        // Periodic target 03 with PRESCALE=2: done every 8 clocks
        do_start(8'h03, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check_eq("ar_cnt", 32'({b_hi, b_lo}), 32'((k % 8) / 2));
            check_eq("ar_done", 32'(b_done), 32'((k % 8) == 0));
            check_eq("ar_state", 32'(b_state), 32'd1);
        end
        do_clear();

        // Illegal target rejected in IDLE
        do_start(8'h1A, 1'b0);
        check_eq("ill_err", 32'({a_err, b_err}), 32'b11);
        check_eq("ill_state", 32'(a_state), 32'd0);
        check_eq("ill_cnt", 32'({a_hi, a_lo}), 32'h00);
        step(1);
        check_eq("ill_err_pulse", 32'(a_err), 32'd0);

        // Full range 00..99 one-shot
        do_start(8'h99, 1'b0);
        check_eq("t99_state", 32'(a_state), 32'd1);
        for (int k = 1; k <= 99; k++) begin
            step(1);
            check_eq("t99_cnt", 32'({a_hi, a_lo}), 32'(bcd8(k)));
        end
        check_eq("t99_cout", 32'(a_cout), 32'd1);
        step(1);
        check_eq("t99_done", 32'(a_done), 32'd1);
        check_eq("t99_state_done", 32'(a_state), 32'd3);
        check_eq("t99_hold", 32'({a_hi, a_lo}), 32'h99);
        check_eq("t99_cout_done", 32'(a_cout), 32'd1);
        // Illegal start from DONE leaves everything alone
        do_start(8'hA0, 1'b1);
        check_eq("ill_done_err", 32'(a_err), 32'd1);
        check_eq("ill_done_state", 32'(a_state), 32'd3);
        check_eq("ill_done_cnt", 32'({a_hi, a_lo}), 32'h99);
        // Illegal start together with clear: err suppressed
        target = 8'h1A;
        start  = 1'b1;
        clear  = 1'b1;
        step(1);
        start  = 1'b0;
        clear  = 1'b0;
        check_eq("clr_sup_err", 32'(a_err), 32'd0);
        check_eq("clr_sup_state", 32'(a_state), 32'd0);

        // Pause at 05 (PRESCALE=2), hold, resume after remaining prescale
        do_start(8'h20, 1'b0);
        step(10);
        check_eq("p_cnt05", 32'({b_hi, b_lo}), 32'h05);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_eq("p_state", 32'(b_state), 32'd2);
        check_eq("p_tick_stop_cnt", 32'({a_hi, a_lo}), 32'h11);
        check_eq("p_tick_stop_state", 32'(a_state), 32'd2);
        step(20);
        check_eq("p_hold_cnt", 32'({b_hi, b_lo}), 32'h05);
        check_eq("p_hold_state", 32'(b_state), 32'd2);
        check_eq("p_busy", 32'(b_busy), 32'd1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_eq("r_state", 32'(b_state), 32'd1);
        check_eq("r_cnt_same", 32'({b_hi, b_lo}), 32'h05);
        step(1);
        check_eq("r_cnt06", 32'({b_hi, b_lo}), 32'h06);
        step(2);
        check_eq("r_cnt07", 32'({b_hi, b_lo}), 32'h07);
        do_clear();

        // Tick + stop on a one-shot terminal edge goes to DONE
        do_start(8'h02, 1'b0);
        step(2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_eq("ts_state", 32'(a_state), 32'd3);
        check_eq("ts_done", 32'(a_done), 32'd1);
        check_eq("ts_cnt", 32'({a_hi, a_lo}), 32'h02);
        do_clear();

        // Target 00 terminates on first tick
        do_start(8'h00, 1'b0);
        check_eq("t00_state_run", 32'(a_state), 32'd1);
        step(1);
        check_eq("t00_done", 32'(a_done), 32'd1);
        check_eq("t00_state", 32'(a_state), 32'd3);
        do_clear();
        // Clear on the terminal edge suppresses done
        do_start(8'h00, 1'b0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check_eq("t00_clr_done", 32'(a_done), 32'd0);
        check_eq("t00_clr_state", 32'(a_state), 32'd0);

        // start+stop+clear together in RUN
        do_start(8'h05, 1'b0);
        step(3);
        check_eq("ssc_pre", 32'({b_hi, b_lo}), 32'h01);
        start = 1'b1;
        stop  = 1'b1;
        clear = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        check_eq("ssc_state", 32'({a_state, b_state}), 32'd0);
        check_eq("ssc_cnt", 32'({b_hi, b_lo}), 32'h00);
        // stop+start in PAUSE stays in PAUSE
        do_start(8'h05, 1'b0);
        step(2);
        stop = 1'b1;
        step(1);
        check_eq("ps_pause", 32'(b_state), 32'd2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        check_eq("ps_stay", 32'(b_state), 32'd2);
        check_eq("ps_cnt", 32'({b_hi, b_lo}), 32'h01);
        do_clear();
        check_eq("ps_clr", 32'(b_state), 32'd0);

        // Asynchronous reset mid-count at 07
        do_start(8'h20, 1'b0);
        step(7);
        check_eq("ar07_cnt", 32'({a_hi, a_lo}), 32'h07);
        #3;
        rstn = 1'b0;
        #1;
        check_eq("arst_cnt", 32'({a_hi, a_lo}), 32'h00);
        check_eq("arst_state", 32'(a_state), 32'd0);
        check_eq("arst_flags", 32'({a_busy, a_cout}), 32'd0);
        #2;
        rstn = 1'b1;
        step(3);
        check_eq("post_rst_idle", 32'(a_state), 32'd0);
        check_eq("post_rst_cnt", 32'({a_hi, a_lo}), 32'h00);
        do_start(8'h20, 1'b0);
        step(1);
        check_eq("post_rst_run", 32'({a_hi, a_lo}), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
